// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage multiply/divide unit owning the HI/LO pair.
//   - MULT/MULTU and MTHI/MTLO commit in one cycle.
//   - MADD/MADDU/MSUB/MSUBU accumulate through a MAC state.
//   - DIV/DIVU run a 32-step restoring divider, then commit from DONE.
// Optional feature macro: MULDIV_MAC_EN. When it is defined, the multiply-
// accumulate opcodes are implemented. When it is undefined, those opcodes
// act as NOPs and the MAC datapath is not built.
//
// Handshake with the stall controller: stallreq is combinational and asks
// the pipeline to hold EX. It is high in the issue cycle of a divide or MAC
// op and during every DIV_RUN cycle. stall[3]=1 means that EX is being held
// downstream. In that case MULT/MTHI/MTLO do not write, and MAC/DONE keep
// their pending result until stall[3] drops. The commit happens on the
// first edge with stall[3]=0.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Opcode encodings shared with the ID-stage decoder (EXE_*_OP)
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MAC     = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Architectural HI/LO
    logic [31:0] hi;
    logic [31:0] lo;

    // Divider working registers
    logic [4:0]  cnt;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_den;
    logic        div_neg_q;
    logic        div_neg_r;

    // Result pending in DONE
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Opcode decode, only meaningful while IDLE
    logic ex_hold;
    logic is_mult;
    logic is_mthi;
    logic is_mtlo;
    logic is_div;
    logic is_mac;
    logic mul_signed;
    logic div_signed;

    // Only stall[3] (EX held) matters to this unit
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:4], stall[2:0]};

    assign ex_hold    = stall[3];
    assign is_mult    = (aluop == OP_MULT) | (aluop == OP_MULTU);
    assign is_mthi    = (aluop == OP_MTHI);
    assign is_mtlo    = (aluop == OP_MTLO);
    assign is_div     = (aluop == OP_DIV) | (aluop == OP_DIVU);
    assign div_signed = (aluop == OP_DIV);
    assign mul_signed = (aluop == OP_MULT) | (aluop == OP_MADD) | (aluop == OP_MSUB);

`ifdef MULDIV_MAC_EN
    logic        mac_sub_op;
    logic [63:0] mac_prod;
    logic        mac_sub;
    logic [63:0] mac_acc;

    assign is_mac     = (aluop == OP_MADD) | (aluop == OP_MADDU) |
                        (aluop == OP_MSUB) | (aluop == OP_MSUBU);
    assign mac_sub_op = (aluop == OP_MSUB) | (aluop == OP_MSUBU);
    assign mac_acc    = mac_sub ? ({hi, lo} - mac_prod) : ({hi, lo} + mac_prod);
`else
    assign is_mac = 1'b0;
`endif

    // One shared 64-bit multiplier. The operands are sign- or zero-extended,
    // so the low 64 bits of the product are exact in both modes.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_a   = {(mul_signed ? {32{reg1[31]}} : 32'h0), reg1};
    assign mul_b   = {(mul_signed ? {32{reg2[31]}} : 32'h0), reg2};
    assign product = mul_a * mul_b;

    // The divider works on magnitudes; signed ops take absolute values here
    logic [31:0] abs1;
    logic [31:0] abs2;

    assign abs1 = (div_signed && reg1[31]) ? (32'd0 - reg1) : reg1;
    assign abs2 = (div_signed && reg2[31]) ? (32'd0 - reg2) : reg2;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract when the divisor fits.
    logic [33:0] div_diff;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] fix_rem;
    logic [31:0] fix_quo;

    assign div_diff = {1'b0, div_rem, div_quo[31]} - {2'b00, div_den};

    // Select restored or subtracted remainder for this step
    always_comb begin
        rem_n = {div_rem[30:0], div_quo[31]};
        quo_n = {div_quo[30:0], 1'b0};
        if (!div_diff[33]) begin
            rem_n = div_diff[31:0];
            quo_n = {div_quo[30:0], 1'b1};
        end
    end

    // Signed fixup: quotient negated on sign mismatch, remainder follows dividend
    assign fix_quo = div_neg_q ? (32'd0 - quo_n) : quo_n;
    assign fix_rem = div_neg_r ? (32'd0 - rem_n) : rem_n;

    // Stall request: issue cycle of a multi-cycle op, plus the whole divide
    assign stallreq = rst & (((state == S_IDLE) & (is_div | is_mac)) |
                             (state == S_DIV_RUN));

    // Next-state selection; flush always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (is_div) begin
                    state_n = (reg2 == 32'd0) ? S_DONE : S_DIV_RUN;
                end else if (is_mac) begin
                    state_n = S_MAC;
                end
            end
`ifdef MULDIV_MAC_EN
            S_MAC: begin
                if (!ex_hold) begin
                    state_n = S_IDLE;
                end
            end
`endif
            S_DIV_RUN: begin
                if (cnt == 5'd31) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (!ex_hold) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (flush) begin
            state_n = S_IDLE;
        end
    end

    // State register and registered busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != S_IDLE);
        end
    end

    // HI/LO, divider and accumulator datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi        <= 32'd0;
            lo        <= 32'd0;
            cnt       <= 5'd0;
            div_rem   <= 32'd0;
            div_quo   <= 32'd0;
            div_den   <= 32'd0;
            div_neg_q <= 1'b0;
            div_neg_r <= 1'b0;
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
`ifdef MULDIV_MAC_EN
            mac_prod  <= 64'd0;
            mac_sub   <= 1'b0;
`endif
        end else if (flush) begin
            // Abort: nothing commits, the divider restarts from scratch
            cnt <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mult && !ex_hold) begin
                        {hi, lo} <= product;
                    end
                    if (is_mthi && !ex_hold) begin
                        hi <= reg1;
                    end
                    if (is_mtlo && !ex_hold) begin
                        lo <= reg1;
                    end
`ifdef MULDIV_MAC_EN
                    if (is_mac) begin
                        mac_prod <= product;
                        mac_sub  <= mac_sub_op;
                    end
`endif
                    if (is_div) begin
                        if (reg2 == 32'd0) begin
                            res_hi <= reg1;
                            res_lo <= 32'hFFFF_FFFF;
                        end else begin
                            div_rem   <= 32'd0;
                            div_quo   <= abs1;
                            div_den   <= abs2;
                            div_neg_q <= div_signed & (reg1[31] ^ reg2[31]);
                            div_neg_r <= div_signed & reg1[31];
                            cnt       <= 5'd0;
                        end
                    end
                end
`ifdef MULDIV_MAC_EN
                S_MAC: begin
                    if (!ex_hold) begin
                        {hi, lo} <= mac_acc;
                    end
                end
`endif
                S_DIV_RUN: begin
                    div_rem <= rem_n;
                    div_quo <= quo_n;
                    if (cnt == 5'd31) begin
                        res_hi <= fix_rem;
                        res_lo <= fix_quo;
                        cnt    <= 5'd0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (!ex_hold) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o      = hi;
    assign lo_o      = lo;
    assign dbg_state = state;

endmodule
